// File: rtl/motor_ramp_ctrl.sv
// Motor PWM sequencer: ramps the PWM level toward a commanded speed, and on a
// direction reversal ramps to zero, holds a bridge-off dead-time, then ramps back up.
module motor_ramp_ctrl #(
  parameter int TICK_DIV    = 4,
  parameter int RAMP_DIV    = 1024,
  parameter int STEP        = 1,
  parameter int DEAD_CYCLES = 5000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       cmd_valid_in,
  output logic       cmd_ready_out,
  input  logic       cmd_dir_in,
  input  logic [7:0] cmd_speed_in,
  input  logic       estop_in,
  output logic [7:0] level_out,
  output logic       enable_out,
  output logic       tick_out,
  output logic       dir_out,
  output logic       at_target_out,
  output logic       fault_out
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RAMP_MAX = RW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DEAD_MAX = DW'(DEAD_CYCLES - 1);
  localparam logic [8:0]    STEP9    = 9'(STEP);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD, S_FAULT} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;
  logic          tick_q, tick_d, ramp_stb_q, ramp_stb_d;
  logic [7:0]    level_q, level_d, tgt_spd_q, tgt_spd_d;
  logic          dir_q, dir_d, tgt_dir_q, tgt_dir_d;
  logic          en_q, en_d, fault_q, fault_d, at_tgt_q, at_tgt_d;
  logic          accept;
  logic [8:0]    up_sum;
  logic [7:0]    toward, sat_dn;

  assign cmd_ready_out = ~estop_in;
  assign accept        = cmd_valid_in & ~estop_in;
  assign level_out     = level_q;
  assign enable_out    = en_q;
  assign tick_out      = tick_q;
  assign dir_out       = dir_q;
  assign at_target_out = at_tgt_q;
  assign fault_out     = fault_q;

  // One ramp step: toward target clamped without overshoot, or saturating down.
  always_comb begin
    up_sum = {1'b0, level_q} + STEP9;
    toward = tgt_spd_q;
    if (level_q < tgt_spd_q)
      toward = (up_sum > {1'b0, tgt_spd_q}) ? tgt_spd_q : up_sum[7:0];
    else if (level_q > tgt_spd_q)
      toward = ({1'b0, level_q} > ({1'b0, tgt_spd_q} + STEP9)) ? (level_q - STEP9[7:0]) : tgt_spd_q;
    sat_dn = ({1'b0, level_q} > STEP9) ? (level_q - STEP9[7:0]) : 8'd0;
  end

  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_MAX) ? '0 : tick_cnt_q + 1'b1;
    tick_d     = (tick_cnt_q == TICK_MAX);
    ramp_cnt_d = (ramp_cnt_q == RAMP_MAX) ? '0 : ramp_cnt_q + 1'b1;
    ramp_stb_d = (ramp_cnt_q == RAMP_MAX);
    state_d    = state_q;
    level_d    = level_q;
    dir_d      = dir_q;
    dead_cnt_d = '0;
    tgt_spd_d  = tgt_spd_q;
    tgt_dir_d  = tgt_dir_q;
    // In FAULT only a zero-speed command is allowed to land in the target.
    if (accept && (state_q != S_FAULT || cmd_speed_in == 8'd0)) begin
      tgt_spd_d = cmd_speed_in;
      tgt_dir_d = cmd_dir_in;
    end
    case (state_q)
      S_IDLE: begin
        level_d = 8'd0;
        if (accept && cmd_speed_in != 8'd0)
          state_d = (cmd_dir_in == dir_q) ? S_RUN : S_DEAD;
      end
      S_RUN: begin
        if (ramp_stb_q) begin
          if (tgt_dir_q != dir_q) begin
            if (level_q == 8'd0) state_d = S_DEAD;
            else                 level_d = sat_dn;
          end else if (level_q == 8'd0 && tgt_spd_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            level_d = toward;
          end
        end
      end
      S_DEAD: begin
        level_d = 8'd0;
        if (dead_cnt_q == DEAD_MAX) begin
          dir_d   = tgt_dir_q;
          state_d = (tgt_spd_q != 8'd0) ? S_RUN : S_IDLE;
        end else begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end
      S_FAULT: begin
        level_d = 8'd0;
        if (accept && cmd_speed_in == 8'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (estop_in) begin
      state_d    = S_FAULT;
      level_d    = 8'd0;
      dir_d      = dir_q;
      dead_cnt_d = '0;
    end
    en_d     = (state_d == S_RUN);
    fault_d  = (state_d == S_FAULT);
    at_tgt_d = (state_d == S_IDLE || state_d == S_RUN) &&
               (level_d == tgt_spd_d) && (dir_d == tgt_dir_d);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      ramp_cnt_q <= '0;
      dead_cnt_q <= '0;
      tick_q     <= 1'b0;
      ramp_stb_q <= 1'b0;
      level_q    <= 8'd0;
      tgt_spd_q  <= 8'd0;
      dir_q      <= 1'b1;
      tgt_dir_q  <= 1'b1;
      en_q       <= 1'b0;
      fault_q    <= 1'b0;
      at_tgt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      ramp_cnt_q <= ramp_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      tick_q     <= tick_d;
      ramp_stb_q <= ramp_stb_d;
      level_q    <= level_d;
      tgt_spd_q  <= tgt_spd_d;
      dir_q      <= dir_d;
      tgt_dir_q  <= tgt_dir_d;
      en_q       <= en_d;
      fault_q    <= fault_d;
      at_tgt_q   <= at_tgt_d;
    end
  end
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: two instances (STEP=1 and STEP=3) driven in lockstep,
// checked against directed tables, level-sequence traces and a behavioural model.
module tb_motor_ramp_ctrl;
  localparam int TDIV = 4, RDIV = 8, DEAD = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_DEAD = 2, M_FAULT = 3;

  logic clk = 1'b0, rst_n = 1'b1;
  logic cmd_valid = 1'b0, cmd_dir = 1'b0, estop = 1'b0;
  logic [7:0] cmd_speed = 8'd0;
  logic       rdy_o[2], en_o[2], tick_o[2], dir_o[2], at_o[2], flt_o[2];
  logic [7:0] lvl_o[2];

  always #5 clk = ~clk;

  motor_ramp_ctrl #(.TICK_DIV(TDIV), .RAMP_DIV(RDIV), .STEP(1), .DEAD_CYCLES(DEAD)) u_s1 (
    .clk_in(clk), .rst_n_in(rst_n), .cmd_valid_in(cmd_valid), .cmd_ready_out(rdy_o[0]),
    .cmd_dir_in(cmd_dir), .cmd_speed_in(cmd_speed), .estop_in(estop), .level_out(lvl_o[0]),
    .enable_out(en_o[0]), .tick_out(tick_o[0]), .dir_out(dir_o[0]),
    .at_target_out(at_o[0]), .fault_out(flt_o[0]));
  motor_ramp_ctrl #(.TICK_DIV(TDIV), .RAMP_DIV(RDIV), .STEP(3), .DEAD_CYCLES(DEAD)) u_s3 (
    .clk_in(clk), .rst_n_in(rst_n), .cmd_valid_in(cmd_valid), .cmd_ready_out(rdy_o[1]),
    .cmd_dir_in(cmd_dir), .cmd_speed_in(cmd_speed), .estop_in(estop), .level_out(lvl_o[1]),
    .enable_out(en_o[1]), .tick_out(tick_o[1]), .dir_out(dir_o[1]),
    .at_target_out(at_o[1]), .fault_out(flt_o[1]));

  typedef struct { int st; int lvl; bit dir; int tspd; bit tdir; int dead_left; bit at; } m_t;
  typedef struct { bit v; bit d; int s; bit es; int w; int l1; int l3; bit en; bit dir; bit flt; bit at; } vec_t;

  int n_chk = 0, n_fail = 0, ecount = 0;
  m_t m[2];
  int q1[$], q3[$], e1[$], e3[$];
  int en0[2];
  vec_t tv[11];

  function automatic m_t m_rst();
    m_t r;
    r.st = M_IDLE; r.lvl = 0; r.dir = 1'b1; r.tspd = 0; r.tdir = 1'b1; r.dead_left = 0; r.at = 1'b0;
    return r;
  endfunction

  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction

  function automatic m_t m_next(m_t c, int step, bit strobe, bit v, bit cdir, int cspd, bit es);
    m_t n = c;
    bit acc = v && !es;
    if (acc && (c.st != M_FAULT || cspd == 0)) begin n.tspd = cspd; n.tdir = cdir; end
    if (es) begin
      n.st = M_FAULT;
    end else begin
      case (c.st)
        M_IDLE: if (acc && cspd != 0) begin
          if (cdir == c.dir) n.st = M_RUN;
          else begin n.st = M_DEAD; n.dead_left = DEAD; end
        end
        M_RUN: if (strobe) begin
          if (c.tdir != c.dir) begin
            if (c.lvl == 0) begin n.st = M_DEAD; n.dead_left = DEAD; end
            else n.lvl = imax(c.lvl - step, 0);
          end else if (c.lvl == 0 && c.tspd == 0) n.st = M_IDLE;
          else if (c.lvl < c.tspd) n.lvl = imin(c.lvl + step, c.tspd);
          else n.lvl = imax(c.lvl - step, c.tspd);
        end
        M_DEAD: if (c.dead_left == 1) begin
          n.dir = c.tdir;
          n.st = (c.tspd != 0) ? M_RUN : M_IDLE;
        end else n.dead_left = c.dead_left - 1;
        default: if (acc && cspd == 0) n.st = M_IDLE;
      endcase
    end
    if (n.st != M_RUN) n.lvl = 0;
    n.at = (n.st == M_IDLE || n.st == M_RUN) && n.lvl == n.tspd && n.dir == n.tdir;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [13:0] act_vec(int i);
    return {rdy_o[i], lvl_o[i], en_o[i], tick_o[i], dir_o[i], at_o[i], flt_o[i]};
  endfunction

  function automatic logic [13:0] exp_vec(int i);
    bit tk = (ecount > 0) && (ecount % TDIV == 0);
    return {~estop, 8'(m[i].lvl), m[i].st == M_RUN, tk, m[i].dir, m[i].at, m[i].st == M_FAULT};
  endfunction

  task automatic cyc(input bit v, input bit d, input int s, input bit es);
    bit stb;
    cmd_valid = v; cmd_dir = d; cmd_speed = 8'(s); estop = es;
    @(posedge clk);
    ecount++;
    stb = (ecount > 1) && ((ecount - 1) % RDIV == 0);
    m[0] = m_next(m[0], 1, stb, v, d, s, es);
    m[1] = m_next(m[1], 3, stb, v, d, s, es);
    #1;
    chk($sformatf("model_s1_edge%0d", ecount), 32'(act_vec(0)), 32'(exp_vec(0)));
    chk($sformatf("model_s3_edge%0d", ecount), 32'(act_vec(1)), 32'(exp_vec(1)));
  endtask

  task automatic collect(input int n);
    int p1, p3;
    q1.delete(); q3.delete(); en0[0] = 0; en0[1] = 0;
    p1 = lvl_o[0]; p3 = lvl_o[1];
    for (int k = 0; k < n; k++) begin
      cyc(0, 0, 0, 0);
      if (lvl_o[0] != 8'(p1)) begin p1 = lvl_o[0]; q1.push_back(p1); end
      if (lvl_o[1] != 8'(p3)) begin p3 = lvl_o[1]; q3.push_back(p3); end
      if (!en_o[0]) en0[0]++;
      if (!en_o[1]) en0[1]++;
    end
  endtask

  task automatic cmp_seq(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_len"}, got.size(), exp.size());
    for (int k = 0; k < exp.size() && k < got.size(); k++)
      chk($sformatf("%s_%0d", nm, k), got[k], exp[k]);
  endtask

  localparam logic [13:0] RST_VEC = {1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    logic [11:0] tmask;
    int es_left, r, spd, k;
    //             v  d  s   es  w    l1   l3  en dir flt at
    tv[0]  = '{1'b1, 1'b1,   5, 1'b0,   80,   5,   5, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[1]  = '{1'b1, 1'b0,   3, 1'b0,  150,   3,   3, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[2]  = '{1'b0, 1'b0,   0, 1'b1,    0,   0,   0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 1'b1,   7, 1'b0,   20,   0,   0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 1'b0,   0, 1'b0,    2,   0,   0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 1'b1,   7, 1'b0,  120,   7,   7, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[6]  = '{1'b1, 1'b1,   0, 1'b0,  120,   0,   0, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 1'b0,   0, 1'b0,   20,   0,   0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 255, 1'b0, 2200, 255, 255, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 1'b1, 254, 1'b0,   30, 254, 254, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[10] = '{1'b1, 1'b1,   0, 1'b0, 2200,   0,   0, 1'b0, 1'b1, 1'b0, 1'b1};

    m[0] = m_rst(); m[1] = m_rst();
    #1 rst_n = 1'b0;
    #12;
    chk("reset_s1", 32'(act_vec(0)), 32'(RST_VEC));
    chk("reset_s3", 32'(act_vec(1)), 32'(RST_VEC));
    @(negedge clk) rst_n = 1'b1;

    tmask = '0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0);
      tmask[i] = tick_o[0];
    end
    chk("tick_edges", 32'(tmask), 32'h888);

    for (int i = 0; i < 11; i++) begin
      cyc(tv[i].v, tv[i].d, tv[i].s, tv[i].es);
      for (int j = 0; j < tv[i].w; j++) cyc(0, 0, 0, 0);
      chk($sformatf("row%0d_lvl_s1", i), lvl_o[0], tv[i].l1);
      chk($sformatf("row%0d_lvl_s3", i), lvl_o[1], tv[i].l3);
      chk($sformatf("row%0d_en", i), en_o[0], tv[i].en);
      chk($sformatf("row%0d_dir", i), dir_o[0], tv[i].dir);
      chk($sformatf("row%0d_fault", i), flt_o[0], tv[i].flt);
      chk($sformatf("row%0d_at", i), at_o[0], tv[i].at);
    end

    cyc(1, 1, 5, 0); collect(80);
    e1 = '{1, 2, 3, 4, 5}; e3 = '{3, 5};
    cmp_seq("up5_s1", q1, e1); cmp_seq("up5_s3", q3, e3);

    cyc(1, 0, 3, 0); collect(150);
    e1 = '{4, 3, 2, 1, 0, 1, 2, 3}; e3 = '{2, 0, 3};
    cmp_seq("rev_s1", q1, e1); cmp_seq("rev_s3", q3, e3);
    chk("dead_len_s1", en0[0], DEAD);
    chk("dead_len_s3", en0[1], DEAD);
    chk("rev_dir", dir_o[0], 0);

    cyc(1, 0, 0, 0); collect(60);
    e1 = '{2, 1, 0}; e3 = '{0};
    cmp_seq("stop_s1", q1, e1); cmp_seq("stop_s3", q3, e3);

    cyc(1, 0, 7, 0); collect(100);
    e1 = '{1, 2, 3, 4, 5, 6, 7}; e3 = '{3, 6, 7};
    cmp_seq("up7_s1", q1, e1); cmp_seq("up7_s3", q3, e3);

    cyc(1, 0, 0, 0); collect(100);
    e1 = '{6, 5, 4, 3, 2, 1, 0}; e3 = '{4, 1, 0};
    cmp_seq("dn7_s1", q1, e1); cmp_seq("dn7_s3", q3, e3);
    chk("dn7_idle_en", {en_o[0], en_o[1]}, 0);

    cyc(1, 0, 5, 0);
    k = 0;
    while (lvl_o[0] != 8'd4 && k < 200) begin cyc(0, 0, 0, 0); k++; end
    chk("reach_lvl4", lvl_o[0], 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_s1", 32'(act_vec(0)), 32'(RST_VEC));
    chk("async_rst_s3", 32'(act_vec(1)), 32'(RST_VEC));
    m[0] = m_rst(); m[1] = m_rst(); ecount = 0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
    chk("post_rst_idle", {lvl_o[0], en_o[0], dir_o[0], at_o[0], flt_o[0]}, {8'd0, 4'b0110});

    es_left = 0;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 9);
      spd = (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(1, 40);
      if (es_left > 0) es_left--;
      else if ($urandom_range(0, 499) == 0) es_left = $urandom_range(1, 3);
      cyc($urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)), spd, es_left > 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
Sequencer that drives the motor PWM generator's level, enable and tick inputs, plus an H-bridge direction line. Accepts speed/direction commands over a valid/ready handshake. Ramps the PWM level toward the target at a fixed rate, and on a direction reversal ramps down, holds a dead-time with the bridge disabled, then ramps back up. Sits between the command source (UI/control loop) and the pwm block.

Parameters:
TICK_DIV, 4, clocks per tick_out pulse (PWM period = 256*TICK_DIV clocks); must be >= 1
RAMP_DIV, 1024, clocks per ramp strobe (one level step per strobe); must be >= 1
STEP, 1, level change per ramp strobe (1..255)
DEAD_CYCLES, 5000, clocks the bridge is held disabled during a direction change; must be >= 1

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
cmd_valid_in  input  1  command valid
cmd_ready_out  output  1  command ready; combinational, equal to ~estop_in
cmd_dir_in  input  1  requested direction, 1 = forward
cmd_speed_in  input  8  requested PWM level, 0..255
estop_in  input  1  emergency stop, level-sensitive
level_out  output  8  PWM level to pwm level_in
enable_out  output  1  PWM enable to pwm enable
tick_out  output  1  PWM count-advance strobe to pwm tick_in
dir_out  output  1  H-bridge direction
at_target_out  output  1  level and direction equal the latched target
fault_out  output  1  high while in FAULT

Behaviour:
- Reset (async, rst_n_in low): state=IDLE, level_out=0, enable_out=0, tick_out=0, dir_out=1, fault_out=0, target speed=0, target dir=1, prescalers=0. All outputs take these values immediately, without waiting for a clock edge.
- Tick prescaler counts 0..TICK_DIV-1 and runs freely in every state. tick_out is registered and high for exactly one clock each wrap, so the first pulse is on the TICK_DIV-th rising edge after reset release.
- Ramp prescaler is built the same way with RAMP_DIV and produces an internal strobe. The strobe is free-running and not reset on state change.
- Handshake: a command is accepted when cmd_valid_in && cmd_ready_out. Accepting latches the target speed and target dir. There is no queue; the newest command overwrites the target.
- States: IDLE, RUN, DEAD, FAULT. Per state:
  - IDLE: level=0, enable=0.
    - Accepted command with speed!=0 and dir==dir_out -> RUN.
    - Accepted command with speed!=0 and dir!=dir_out -> DEAD.
    - Speed-0 commands remain in IDLE.
  - RUN: enable=1. On each strobe:
    - If target dir != dir_out: level decrements by STEP, saturating at 0. When level==0 -> DEAD (enable=0 from that same edge).
    - Else: level moves toward target speed by STEP, clamped to the target with no overshoot. Use a 9-bit intermediate with no wrap past 0 or 255.
    - If level==0 and target speed==0 -> IDLE.
  - DEAD: level=0, enable=0. Counts DEAD_CYCLES clocks, then sets dir_out=target dir and goes to RUN if target speed!=0, else IDLE. Commands are accepted during DEAD; the full dead-time always completes.
  - FAULT: level=0, enable=0, fault_out=1.
    - Exit to IDLE only on an accepted command with speed==0; this also sets the target to 0. dir_out is unchanged.
    - Nonzero commands are accepted (when estop_in is low) and discarded.
- estop_in high in any state: on the next edge, state=FAULT, level=0, enable=0. Because cmd_ready_out=0 while estop_in is high, a command in the same cycle is not accepted.
- A strobe coinciding with command acceptance: the step uses the old target; the new target applies from the next strobe.
- at_target_out (registered) = (state in IDLE/RUN) && level==target speed && dir_out==target dir.

Test Plan:
- Reset, then release with TICK_DIV=4 -> all outputs 0 except dir_out=1 and cmd_ready_out=1. tick_out is high one clock on edges 4, 8, 12 after release.
- RAMP_DIV=8, STEP=1; command fwd/5 from IDLE -> RUN, enable=1, level steps 1,2,3,4,5 one per 8 clocks. at_target_out rises with level=5, and level holds at 5.
- At fwd/5, command rev/3 with DEAD_CYCLES=10 -> level 4..0, then enable=0 and level=0 for 10 clocks. dir_out goes to 0, then level steps 1,2,3 and at_target_out=1.
- estop_in pulsed at level 3 -> next edge gives level=0, enable=0, fault_out=1, and ready stays 0 while estop_in is high. After release, command fwd/7 leaves the block in FAULT; command fwd/0 returns it to IDLE with fault_out=0.
- STEP=3, command fwd/7 -> level 3,6,7 with no overshoot. Then command fwd/0 -> level 4,1,0, then IDLE with enable=0.
- rst_n_in asserted between clock edges mid-ramp (level=4) -> level_out=0 and enable_out=0 before the next edge. After release the block restarts in IDLE with target 0.
